// File: rtl/mult_div_unit_pkg.sv
// Shared operation codes, default latencies and small helpers for the
// multiply/divide unit and its arithmetic core.
package mult_div_unit_pkg;

   localparam int MD_OP_WIDTH = 3;

   localparam logic [MD_OP_WIDTH-1:0] MD_NONE  = 3'd0;
   localparam logic [MD_OP_WIDTH-1:0] MD_MULT  = 3'd1;
   localparam logic [MD_OP_WIDTH-1:0] MD_MULTU = 3'd2;
   localparam logic [MD_OP_WIDTH-1:0] MD_DIV   = 3'd3;
   localparam logic [MD_OP_WIDTH-1:0] MD_DIVU  = 3'd4;
   localparam logic [MD_OP_WIDTH-1:0] MD_MTHI  = 3'd5;
   localparam logic [MD_OP_WIDTH-1:0] MD_MTLO  = 3'd6;

   localparam int DEFAULT_MULT_CYCLES = 5;
   localparam int DEFAULT_DIV_CYCLES  = 10;

   // Only these codes occupy the unit for more than one cycle.
   function automatic logic is_md_op(input logic [MD_OP_WIDTH-1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [MD_OP_WIDTH-1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic int cnt_bits(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/mult_div_unit_md_core.sv
// Combinational signed/unsigned product, quotient and remainder, including
// the divide-by-zero (no write) and signed-overflow rules.
module md_core
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [MD_OP_WIDTH-1:0] i_op,
   input  logic [WIDTH-1:0]       i_a,
   input  logic [WIDTH-1:0]       i_b,
   output logic [WIDTH-1:0]       o_hi,
   output logic [WIDTH-1:0]       o_lo,
   output logic                   o_wr
);

   logic               w_signed;
   logic               w_is_div;
   logic               w_neg_a;
   logic               w_neg_b;
   logic [2*WIDTH-1:0] w_ext_a;
   logic [2*WIDTH-1:0] w_ext_b;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH-1:0]   w_divisor;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
   assign w_is_div = is_div_op(i_op);
   assign w_neg_a  = w_signed & i_a[WIDTH-1];
   assign w_neg_b  = w_signed & i_b[WIDTH-1];

   // Sign-extending to 2W bits lets one unsigned multiplier serve both flavours.
   assign w_ext_a = {{WIDTH{w_neg_a}}, i_a};
   assign w_ext_b = {{WIDTH{w_neg_b}}, i_b};
   assign w_prod  = w_ext_a * w_ext_b;

   assign w_mag_a   = w_neg_a ? -i_a : i_a;
   assign w_mag_b   = w_neg_b ? -i_b : i_b;
   assign w_divisor = (i_b == '0) ? WIDTH'(1) : w_mag_b;
   assign w_quo     = w_mag_a / w_divisor;
   assign w_rem     = w_mag_a % w_divisor;

   // -2^(W-1) / -1 yields magnitude 2^(W-1), which wraps back to -2^(W-1) with rem 0.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      o_hi = w_prod[2*WIDTH-1:WIDTH];
      o_lo = w_prod[WIDTH-1:0];
      o_wr = 1'b1;
      if (w_is_div) begin
         o_lo = (w_neg_a ^ w_neg_b) ? -w_quo : w_quo;
         o_hi = w_neg_a ? -w_rem : w_rem;
         o_wr = (i_b != '0);
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Holds busy for a fixed latency, then commits the latched-operand result.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [MD_OP_WIDTH-1:0] MDOp,
   input  logic [WIDTH-1:0]       A,
   input  logic [WIDTH-1:0]       B,
   output logic                   busy,
   output logic [WIDTH-1:0]       HI,
   output logic [WIDTH-1:0]       LO
);

   localparam int CNT_W = cnt_bits(MULT_CYCLES, DIV_CYCLES);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]             r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [MD_OP_WIDTH-1:0] r_op;
   logic [WIDTH-1:0]       r_hi;
   logic [WIDTH-1:0]       r_lo;

   logic [CNT_W-1:0]       w_load;
   logic [WIDTH-1:0]       w_hi;
   logic [WIDTH-1:0]       w_lo;
   logic                   w_wr;

   assign w_load = is_div_op(MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   md_core #(.WIDTH(WIDTH)) u_md_core (
      .i_op (r_op),
      .i_a  (r_a),
      .i_b  (r_b),
      .o_hi (w_hi),
      .o_lo (w_lo),
      .o_wr (w_wr)
   );

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= MD_NONE;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && is_md_op(MDOp)) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_op    <= MDOp;
                  r_cnt   <= w_load;
                  r_state <= ST_RUN;
               end else if (MDOp == MD_MTHI) begin
                  r_hi <= A;
               end else if (MDOp == MD_MTLO) begin
                  r_lo <= A;
               end
            end
            ST_RUN: begin
               // start and mthi/mtlo are deliberately ignored here; the hazard unit stalls them.
               if (r_cnt == CNT_W'(1)) begin
                  if (w_wr) begin
                     r_hi <= w_hi;
                     r_lo <= w_lo;
                  end
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (r_state == ST_RUN);
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule
